// File: rtl/spu_mem_port_ctrl.sv
// SPU memory port controller: initiator on the 128-bit SPU port (port B) of the
// shared main data memory. Takes burst read/write commands from the SPU, drives the
// memory enable/strobes/address/data, and buffers read returns in a small FIFO with
// valid/ready flow control back to the SPU.
//
// Optional feature (macro SPU_MEM_BOUNDS_CHECK_EN): refuse bursts whose last word
// would fall at or beyond MEM_WORDS, pulsing err and done without touching memory.
// When the macro is undefined, err is tied 0 and addresses wrap modulo 2^ADDR_W.
module spu_mem_port_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_WORDS  = 4096
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [127:0]      wr_data,
  input  logic [15:0]       wr_strb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [127:0]      rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic [15:0]       mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e              state_q, state_d;
  logic                armed_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W:0]      cnt_q, cnt_d;   // write beats accepted / read beats issued
  logic [LEN_W:0]      pop_q, pop_d;   // read beats handed to the SPU
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
  logic [127:0]        fifo_q [FIFO_DEPTH];
  logic [127:0]        fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]     fcnt_q, fcnt_d;
  logic [CntW-1:0]     infl;
  logic [CntW:0]       occ;
  logic                issue, push, pop, bad_cmd;

`ifdef SPU_MEM_BOUNDS_CHECK_EN
  logic                err_q, err_d;
  logic [ADDR_W:0]     end_addr;

  // Last word of the burst, computed one bit wider so it cannot wrap past the check.
  always_comb begin
    end_addr = {1'b0, cmd_addr} + (ADDR_W + 1)'(cmd_len);
    bad_cmd  = end_addr >= (ADDR_W + 1)'(MEM_WORDS);
  end

  assign err = err_q;
`else
  logic unused_mem_words;
  assign unused_mem_words = ^MEM_WORDS;
  assign bad_cmd = 1'b0;
  assign err     = 1'b0;
`endif

  // Read-return flow: FIFO head is presented whenever the FIFO holds data.
  assign rd_valid = (fcnt_q != '0);
  assign rd_data  = rd_valid ? fifo_q[rptr_q] : '0;
  assign rd_last  = rd_valid && (pop_q == {1'b0, len_q});
  assign pop      = rd_valid && rd_ready;
  assign push     = vpipe_q[RD_LAT-1];
  assign done     = done_q;

  // Reads in flight in the memory pipeline plus FIFO occupancy bound new issues.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + CntW'(vpipe_q[i]);
    end
    occ = {1'b0, fcnt_q} + {1'b0, infl};
  end

  // Main FSM: command accept, write beat forwarding, read issue and completion.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pop_d     = pop_q;
    done_d    = 1'b0;
`ifdef SPU_MEM_BOUNDS_CHECK_EN
    err_d     = 1'b0;
`endif
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = armed_q;
        if (cmd_valid && armed_q) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          pop_d  = '0;
          if (bad_cmd) begin
            // Refused burst: no memory access, just report and stay idle.
            done_d = 1'b1;
`ifdef SPU_MEM_BOUNDS_CHECK_EN
            err_d  = 1'b1;
`endif
          end else begin
            state_d = cmd_write ? StWr : StRd;
          end
        end
      end

      StWr: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en    = 1'b1;
          mem_we    = wr_strb;
          mem_addr  = addr_q;
          mem_wdata = wr_data;
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q + (LEN_W + 1)'(1);
          if (cnt_q == {1'b0, len_q}) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StRd: begin
        if ((occ < DepthC) && (cnt_q <= {1'b0, len_q})) begin
          issue    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = addr_q;
          addr_d   = addr_q + ADDR_W'(1);
          cnt_d    = cnt_q + (LEN_W + 1)'(1);
        end
        if (pop) begin
          pop_d = pop_q + (LEN_W + 1)'(1);
          if (pop_q == {1'b0, len_q}) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Read valid pipe and return FIFO bookkeeping.
  always_comb begin
    vpipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (push) begin
      fifo_d[wptr_q] = mem_rdata;
      wptr_d         = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      fcnt_d = fcnt_q + CntW'(1);
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - CntW'(1);
    end
  end

  // State registers; reset aborts any burst and flushes the read path.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pop_q   <= '0;
      done_q  <= 1'b0;
      vpipe_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
`ifdef SPU_MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
      vpipe_q <= vpipe_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fcnt_q  <= fcnt_d;
      fifo_q  <= fifo_d;
`ifdef SPU_MEM_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_spu_mem_port_ctrl.sv
// Directed bench for spu_mem_port_ctrl with a 1-cycle-latency byte-writable memory
// model (256 words, indexed by the low address byte). Inputs change on the falling
// edge; outputs are sampled 1 ns later.
module tb_spu_mem_port_ctrl;

  logic         clk_100mhz = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0]  cmd_addr = '0;
  logic [7:0]   cmd_len = '0;
  logic         wr_valid = 1'b0, wr_ready;
  logic [127:0] wr_data = '0;
  logic [15:0]  wr_strb = '0;
  logic         rd_valid, rd_ready = 1'b0, rd_last, done, err;
  logic [127:0] rd_data;
  logic         mem_en;
  logic [15:0]  mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [127:0] mem [256];
  logic [127:0] exp_w;
  logic [127:0] tmp;
  logic [6:0]   vpat = 7'b1100101;
  int           n_en, k, first_c, last_c, b;

  spu_mem_port_ctrl #(
    .ADDR_W(32), .LEN_W(8), .RD_LAT(1), .FIFO_DEPTH(4), .MEM_WORDS(4096)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial forever #5 clk_100mhz = ~clk_100mhz;

  function automatic logic [127:0] pat(input int unsigned a);
    return {4{32'hC0DE_0000 | a}};
  endfunction

  function automatic logic [127:0] wd(input int unsigned i);
    return {4{32'h5A5A_0000 + i}};
  endfunction

  // Memory model: preloaded while reset is held, read-first, 1-cycle read latency.
  always @(posedge clk_100mhz) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we == 16'h0) mem_rdata <= mem[mem_addr[7:0]];
      for (int j = 0; j < 16; j++) begin
        if (mem_we[j]) mem[mem_addr[7:0]][j*8 +: 8] <= mem_wdata[j*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a command and hold it until accepted; returns on the falling edge after
  // the handshake edge with cmd_valid dropped.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    @(negedge clk_100mhz);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_100mhz);
    end
    chk("cmd_accept", ok, 1'b1);
    @(negedge clk_100mhz);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required $finish before 100 us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk_100mhz);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    // Single write beat
    send_cmd(1'b1, 32'h10, 8'd0);
    exp_w = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    wr_valid = 1'b1;
    wr_data  = exp_w;
    wr_strb  = 16'hFFFF;
    #1;
    chk("wr1_ready", wr_ready, 1'b1);
    chk("wr1_en", mem_en, 1'b1);
    chk("wr1_we", mem_we, 16'hFFFF);
    chk("wr1_addr", mem_addr, 32'h10);
    chk("wr1_wdata", mem_wdata, exp_w);
    @(negedge clk_100mhz);
    wr_valid = 1'b0;
    #1;
    chk("wr1_done", done, 1'b1);
    chk("wr1_en_off", mem_en, 1'b0);
    @(negedge clk_100mhz);
    #1;
    chk("wr1_done_pulse", done, 1'b0);
    chk("wr1_mem", mem[8'h10], exp_w);

    // 4-beat read, always ready
    rd_ready = 1'b1;
    send_cmd(1'b0, 32'h20, 8'd3);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rd4_en", mem_en, (i < 4));
      if (i < 4) chk("rd4_addr", mem_addr, 32'h20 + i);
      chk("rd4_valid", rd_valid, (i >= 2));
      if (i >= 2) begin
        chk("rd4_data", rd_data, pat(32'h20 + i - 2));
        chk("rd4_last", rd_last, (i == 5));
      end
      @(negedge clk_100mhz);
    end
    #1;
    chk("rd4_done", done, 1'b1);
    chk("rd4_valid_end", rd_valid, 1'b0);

    // 8-beat read under backpressure
    rd_ready = 1'b0;
    send_cmd(1'b0, 32'h40, 8'd7);
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_en) n_en++;
      @(negedge clk_100mhz);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    wr_valid  = 1'b1;
    #1;
    chk("bp_issue_count", n_en, 4);
    chk("bp_en_stalled", mem_en, 1'b0);
    chk("bp_rd_valid", rd_valid, 1'b1);
    chk("bp_cmd_ready", cmd_ready, 1'b0);
    chk("bp_wr_ready", wr_ready, 1'b0);
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b1;
    k = 0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (rd_valid) begin
        chk("bp_data", rd_data, pat(32'h40 + k));
        chk("bp_last", rd_last, (k == 7));
        if (first_c < 0) first_c = c;
        last_c = c;
        k++;
      end
      if (k == 8) break;
      @(negedge clk_100mhz);
      #1;
    end
    chk("bp_beats", k, 8);
    chk("bp_no_gaps", last_c - first_c, 7);
    @(negedge clk_100mhz);
    #1;
    chk("bp_done", done, 1'b1);
    rd_ready = 1'b0;

    // Write burst with valid gaps and a partial strobe on beat 2
    send_cmd(1'b1, 32'h80, 8'd3);
    b = 0;
    for (int c = 0; c < 7; c++) begin
      wr_valid = vpat[c];
      wr_data  = wd(b);
      wr_strb  = (b == 2) ? 16'h000F : 16'hFFFF;
      #1;
      chk("wrg_en", mem_en, vpat[c]);
      if (vpat[c]) begin
        chk("wrg_addr", mem_addr, 32'h80 + b);
        chk("wrg_we", mem_we, (b == 2) ? 16'h000F : 16'hFFFF);
        b++;
      end
      @(negedge clk_100mhz);
    end
    wr_valid = 1'b0;
    #1;
    chk("wrg_done", done, 1'b1);
    @(negedge clk_100mhz);
    tmp   = pat(32'h82);
    exp_w = wd(2);
    chk("wrg_partial", mem[8'h82], {tmp[127:32], exp_w[31:0]});
    chk("wrg_full", mem[8'h83], wd(3));

    // Reset in the middle of an 8-beat read after three pops
    rd_ready = 1'b1;
    send_cmd(1'b0, 32'h20, 8'd7);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rd_valid) k++;
      if (k == 3) break;
      @(negedge clk_100mhz);
    end
    chk("rst_mid_pops", k, 3);
    @(negedge clk_100mhz);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_valid", rd_valid, 1'b0);
    chk("rst_mid_rd_data", rd_data, 128'h0);
    chk("rst_mid_mem_en", mem_en, 1'b0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    send_cmd(1'b0, 32'h30, 8'd0);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rd_valid) break;
      @(negedge clk_100mhz);
    end
    chk("post_rst_valid", rd_valid, 1'b1);
    chk("post_rst_data", rd_data, pat(32'h30));
    chk("post_rst_last", rd_last, 1'b1);
    @(negedge clk_100mhz);
    #1;
    chk("post_rst_empty", rd_valid, 1'b0);
    chk("post_rst_done", done, 1'b1);

`ifdef SPU_MEM_BOUNDS_CHECK_EN
    // Out-of-range read is refused
    send_cmd(1'b0, 32'd4094, 8'd3);
    #1;
    chk("oob_mem_en", mem_en, 1'b0);
    chk("oob_err", err, 1'b1);
    chk("oob_done", done, 1'b1);
    chk("oob_rd_valid", rd_valid, 1'b0);
    @(negedge clk_100mhz);
    #1;
    chk("oob_err_pulse", err, 1'b0);
    chk("oob_rd_valid2", rd_valid, 1'b0);
    chk("oob_idle", cmd_ready, 1'b1);
`else
    // Address wraps modulo 2^32 without error
    send_cmd(1'b1, 32'hFFFF_FFFF, 8'd1);
    wr_valid = 1'b1;
    wr_data  = wd(9);
    wr_strb  = 16'hFFFF;
    #1;
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFF);
    @(negedge clk_100mhz);
    #1;
    chk("wrap_addr1", mem_addr, 32'h0);
    chk("wrap_err", err, 1'b0);
    @(negedge clk_100mhz);
    wr_valid = 1'b0;
    #1;
    chk("wrap_done", done, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
